// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer: opcodes,
// FSM states and instruction field positions.
package alu_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int INSTR_W    = 13;

  localparam int OP_LSB  = 10;
  localparam int OP_W    = 3;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 6;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_LOADI = 3'b010,
    OP_RSVD  = 3'b011,
    OP_EQ    = 3'b100,
    OP_GT    = 3'b101,
    OP_LT    = 3'b110,
    OP_ZERO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: 2**REG_AW entries, two combinational read ports,
// one write port, synchronous reset to zero.
module alu_regfile #(
  parameter int DATA_W = 6,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Reads see the pre-write contents, so rd==rs1==rs2 needs no bypass.
  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of the external 6-bit ALU: accepts instructions, runs one
// ALU op each, writes back and responds. Define ALU_ZFLAG_EN for resp_zero.
//
// state   | meaning
// IDLE    | ready for an instruction; LOADI/reserved complete here
// EXEC    | one cycle driving the ALU, result written back at cycle end
// RESP    | response held until resp_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W_DEF,
  parameter int REG_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [2:0]         alu_sel,
  input  logic [DATA_W-1:0]  alu_c,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data,
`ifdef ALU_ZFLAG_EN
  output logic               resp_zero,
`endif
  output logic               resp_err
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
`ifdef ALU_ZFLAG_EN
  logic              resp_zero_q, resp_zero_d;
`endif

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

  op_e               op_in;
  logic [DATA_W-1:0] imm_in;

  assign op_in  = op_e'(instr[OP_LSB +: OP_W]);
  assign imm_in = DATA_W'(instr[IMM_LSB +: IMM_W]);

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (rs1_q),
    .raddr2 (rs2_q),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
`ifdef ALU_ZFLAG_EN
    resp_zero_d = resp_zero_q;
`endif
    rf_we       = 1'b0;
    rf_waddr    = rd_q;
    rf_wdata    = alu_c;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d  = op_in;
          rd_d  = instr[RD_LSB +: REG_AW];
          rs1_d = instr[RS1_LSB +: REG_AW];
          rs2_d = instr[RS2_LSB +: REG_AW];
          case (op_in)
            OP_LOADI: begin
              rf_we       = 1'b1;
              rf_waddr    = instr[RD_LSB +: REG_AW];
              rf_wdata    = imm_in;
              resp_data_d = imm_in;
              resp_err_d  = 1'b0;
`ifdef ALU_ZFLAG_EN
              resp_zero_d = (imm_in == '0);
`endif
              state_d     = ST_RESP;
            end
            OP_RSVD: begin
              resp_data_d = '0;
              resp_err_d  = 1'b1;
`ifdef ALU_ZFLAG_EN
              resp_zero_d = 1'b0;
`endif
              state_d     = ST_RESP;
            end
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        alu_a       = rf_rdata1;
        alu_b       = rf_rdata2;
        alu_sel     = op_q;
        rf_we       = 1'b1;
        rf_waddr    = rd_q;
        rf_wdata    = alu_c;
        resp_data_d = alu_c;
        resp_err_d  = 1'b0;
`ifdef ALU_ZFLAG_EN
        resp_zero_d = (alu_c == '0);
`endif
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
`ifdef ALU_ZFLAG_EN
      resp_zero_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
`ifdef ALU_ZFLAG_EN
      resp_zero_q <= resp_zero_d;
`endif
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
`ifdef ALU_ZFLAG_EN
  assign resp_zero   = resp_zero_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural stand-in for the
// external ALU; expected values are hand-computed.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [12:0] instr;
  logic [5:0]  alu_a, alu_b, alu_c;
  logic [2:0]  alu_sel;
  logic        resp_valid, resp_ready, resp_err;
  logic [5:0]  resp_data;
`ifdef ALU_ZFLAG_EN
  logic        resp_zero;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_c       (alu_c),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
`ifdef ALU_ZFLAG_EN
    .resp_zero   (resp_zero),
`endif
    .resp_err    (resp_err)
  );

  // External ALU stand-in
  always_comb begin
    case (alu_sel)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b100:  alu_c = {5'b0, alu_a == alu_b};
      3'b101:  alu_c = {5'b0, alu_a > alu_b};
      3'b110:  alu_c = {5'b0, alu_a < alu_b};
      default: alu_c = 6'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [5:0] r0, r1, r2, r3);
    chk({tag, "_r0"}, dut.u_rf.regs_q[0], r0);
    chk({tag, "_r1"}, dut.u_rf.regs_q[1], r1);
    chk({tag, "_r2"}, dut.u_rf.regs_q[2], r2);
    chk({tag, "_r3"}, dut.u_rf.regs_q[3], r3);
  endtask

  // Called at posedge+1 with the DUT idle; completes the response handshake.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [1:0] rd, rs1, rs2, input logic [5:0] imm,
                        input logic [5:0] exp_a, exp_b, exp_data,
                        input logic exp_err, exp_zero);
    logic is_alu;
    is_alu = (op != 3'b010) && (op != 3'b011);
    instr = {op, rd, rs1, (op == 3'b010) ? imm : {rs2, 4'b0000}};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk({tag, "_rdy_lo"}, instr_ready, 0);
    if (is_alu) begin
      chk({tag, "_early_valid"}, resp_valid, 0);
      chk({tag, "_alu_a"}, alu_a, exp_a);
      chk({tag, "_alu_b"}, alu_b, exp_b);
      chk({tag, "_alu_sel"}, alu_sel, op);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_err"}, resp_err, exp_err);
`ifdef ALU_ZFLAG_EN
    chk({tag, "_zero"}, resp_zero, exp_zero);
`else
    if (exp_zero !== (exp_data == 6'd0 && !exp_err))
      chk({tag, "_zero_arg"}, exp_zero, (exp_data == 6'd0 && !exp_err));
`endif
    chk({tag, "_sel_idle"}, alu_sel, 0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_done_valid"}, resp_valid, 0);
    chk({tag, "_done_rdy"}, instr_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
`ifdef ALU_ZFLAG_EN
    chk("rst_zero", resp_zero, 0);
`endif

    //      tag      op      rd     rs1    rs2    imm    a      b      data   err zero
    run_op("ldi_r0", 3'b010, 2'd0, 2'd0, 2'd0, 6'd5, 6'd0, 6'd0, 6'd5,  0, 0);
    run_op("ldi_r1", 3'b010, 2'd1, 2'd0, 2'd0, 6'd3, 6'd0, 6'd0, 6'd3,  0, 0);
    run_op("add",    3'b000, 2'd2, 2'd0, 2'd1, 6'd0, 6'd5, 6'd3, 6'd8,  0, 0);
    chk_regs("after_add", 6'd5, 6'd3, 6'd8, 6'd0);
    run_op("sub",    3'b001, 2'd3, 2'd1, 2'd0, 6'd0, 6'd3, 6'd5, 6'd62, 0, 0);
    run_op("lt",     3'b110, 2'd3, 2'd1, 2'd0, 6'd0, 6'd3, 6'd5, 6'd1,  0, 0);
    run_op("gt",     3'b101, 2'd3, 2'd1, 2'd0, 6'd0, 6'd3, 6'd5, 6'd0,  0, 1);
    run_op("eq",     3'b100, 2'd3, 2'd0, 2'd0, 6'd0, 6'd5, 6'd5, 6'd1,  0, 0);
    run_op("zero",   3'b111, 2'd3, 2'd0, 2'd1, 6'd0, 6'd5, 6'd3, 6'd0,  0, 1);
    run_op("rsvd",   3'b011, 2'd0, 2'd1, 2'd1, 6'd0, 6'd0, 6'd0, 6'd0,  1, 0);
    chk_regs("after_rsvd", 6'd5, 6'd3, 6'd8, 6'd0);
    run_op("add_clr_err", 3'b000, 2'd3, 2'd2, 2'd0, 6'd0, 6'd8, 6'd5, 6'd13, 0, 0);

    // rd==rs1==rs2 then backpressure with a stray instruction offered while busy
    instr = {3'b000, 2'd2, 2'd2, 2'd2, 4'b0000};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("haz_alu_a", alu_a, 8);
    @(posedge clk); #1;
    instr = {3'b010, 2'd0, 2'd0, 6'd33};
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, 16);
      chk("hold_rdy", instr_ready, 0);
      if (i == 3) instr_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk_regs("after_hold", 6'd5, 6'd3, 6'd16, 6'd13);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("release_valid", resp_valid, 0);
    chk("release_rdy", instr_ready, 1);

    // reset while in EXEC abandons the op
    instr = {3'b000, 2'd3, 2'd0, 2'd1, 4'b0000};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("pre_rst_exec_sel", alu_sel, 0);
    chk("pre_rst_exec_a", alu_a, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_rdy", instr_ready, 1);
    chk("mid_rst_data", resp_data, 0);
    chk_regs("mid_rst", 6'd0, 6'd0, 6'd0, 6'd0);
    @(posedge clk); #1;
    chk("mid_rst_no_resp", resp_valid, 0);

    run_op("ldi_r0_7", 3'b010, 2'd0, 2'd0, 2'd0, 6'd7, 6'd0, 6'd0, 6'd7, 0, 0);
    run_op("sub_self", 3'b001, 2'd1, 2'd0, 2'd0, 6'd0, 6'd7, 6'd7, 6'd0, 0, 1);
    run_op("ldi_zero", 3'b010, 2'd2, 2'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
